// File: rtl/pgm_ddram_arb_if.sv
// Client and DDRAM-side bus for the PGM DDRAM read arbiter.
// slave: arbiter view. master: clients/memory view.
interface pgm_ddram_arb_if;
  logic        cpu_req;
  logic [28:0] cpu_addr;
  logic        cpu_ack;
  logic [63:0] cpu_data;
  logic        vid_req;
  logic [28:0] vid_addr;
  logic        vid_ack;
  logic [63:0] vid_data;
  logic        snd_req;
  logic [28:0] snd_addr;
  logic        snd_ack;
  logic [63:0] snd_data;
  logic        ldr_active;
  logic [28:0] ldr_addr;
  logic        ldr_we;
  logic [63:0] ldr_din;
  logic [7:0]  ldr_be;
  logic        ddram_busy;
  logic        ddram_dout_ready;
  logic [63:0] ddram_dout;
  logic        ddram_rd;
  logic        ddram_we;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic        timeout_err;

  modport slave (
    input  cpu_req, cpu_addr, vid_req, vid_addr, snd_req, snd_addr,
           ldr_active, ldr_addr, ldr_we, ldr_din, ldr_be,
           ddram_busy, ddram_dout_ready, ddram_dout,
    output cpu_ack, cpu_data, vid_ack, vid_data, snd_ack, snd_data,
           ddram_rd, ddram_we, ddram_addr, ddram_din, ddram_be, timeout_err
  );

  modport master (
    output cpu_req, cpu_addr, vid_req, vid_addr, snd_req, snd_addr,
           ldr_active, ldr_addr, ldr_we, ldr_din, ldr_be,
           ddram_busy, ddram_dout_ready, ddram_dout,
    input  cpu_ack, cpu_data, vid_ack, vid_data, snd_ack, snd_data,
           ddram_rd, ddram_we, ddram_addr, ddram_din, ddram_be, timeout_err
  );
endinterface

// File: rtl/pgm_ddram_arb.sv
// PGM DDRAM read arbiter: syncs level requests from foreign domains, issues
// one read at a time, returns data with a 4-phase level ack per client.
// Client index: 0 = cpu, 1 = vid, 2 = snd.
module pgm_ddram_arb #(
  parameter int STARVE_LIM = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic            clk,
  input  logic            reset_n,
  pgm_ddram_arb_if.slave  bus
);
  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            r_state;
  logic [2:0]        r_req_m, r_req_s, r_ack, r_gnt;
  logic [28:0]       r_addr;
  logic              r_rd, r_tout;
  logic [2:0][63:0]  r_data;
  logic [CW-1:0]     r_starve;
  logic [TW-1:0]     r_wcnt;

  logic [2:0]        w_req, w_elig, w_pick;
  logic [28:0]       w_pick_addr;
  logic              w_done, w_tmo, w_fin, w_ldr;
  logic [63:0]       w_fin_data;

  assign w_req  = {bus.snd_req, bus.vid_req, bus.cpu_req};
  assign w_elig = r_req_s & ~r_ack;

  // A late ready still beats the timeout on the same cycle.
  assign w_done     = (r_state == WAIT) && bus.ddram_dout_ready;
  assign w_tmo      = (r_state != IDLE) && (r_wcnt == TW'(TIMEOUT)) && !w_done;
  assign w_fin      = w_done || w_tmo;
  assign w_fin_data = w_done ? bus.ddram_dout : '1;

  // Grant selection: starved audio jumps the queue, else cpu > vid > snd.
  always_comb begin
    w_pick = 3'b000;
    if (r_starve >= CW'(STARVE_LIM) && w_elig[2]) w_pick = 3'b100;
    else if (w_elig[0])                           w_pick = 3'b001;
    else if (w_elig[1])                           w_pick = 3'b010;
    else if (w_elig[2])                           w_pick = 3'b100;
  end

  // Address of the client about to be granted.
  always_comb begin
    w_pick_addr = bus.cpu_addr;
    if (w_pick[1])      w_pick_addr = bus.vid_addr;
    else if (w_pick[2]) w_pick_addr = bus.snd_addr;
  end

  // Two-flop synchronisers for the foreign-domain request levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_m <= '0;
      r_req_s <= '0;
    end else begin
      r_req_m <= w_req;
      r_req_s <= r_req_m;
    end
  end

  // Arbiter FSM with acks, data capture, wait counter and starvation count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_addr   <= '0;
      r_rd     <= 1'b0;
      r_wcnt   <= '0;
      r_starve <= '0;
      r_ack    <= '0;
      r_data   <= '0;
      r_tout   <= 1'b0;
    end else begin
      r_rd <= 1'b0;
      for (int i = 0; i < 3; i++) if (!r_req_s[i]) r_ack[i] <= 1'b0;
      if (!w_elig[2]) r_starve <= '0;
      if (w_fin) begin
        // Completion sets the ack even if the client already dropped req.
        for (int i = 0; i < 3; i++) begin
          if (r_gnt[i]) begin
            r_data[i] <= w_fin_data;
            r_ack[i]  <= 1'b1;
          end
        end
        if (w_tmo) r_tout <= 1'b1;
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (!bus.ldr_active && |w_elig) begin
              r_gnt   <= w_pick;
              r_addr  <= w_pick_addr;
              r_wcnt  <= '0;
              r_state <= ISSUE;
              if (w_pick[2]) r_starve <= '0;
              else if (w_elig[2] && r_starve != CW'(STARVE_LIM))
                r_starve <= r_starve + CW'(1);
            end
          end
          ISSUE: begin
            r_wcnt <= r_wcnt + TW'(1);
            if (!bus.ddram_busy) begin
              r_rd    <= 1'b1;
              r_state <= WAIT;
            end
          end
          WAIT:    r_wcnt <= r_wcnt + TW'(1);
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Loader owns the write side only while the FSM is idle; reset forces all to 0.
  assign w_ldr = reset_n && bus.ldr_active && (r_state == IDLE);

  assign bus.ddram_rd    = r_rd;
  assign bus.ddram_we    = w_ldr && bus.ldr_we;
  assign bus.ddram_addr  = w_ldr ? bus.ldr_addr : r_addr;
  assign bus.ddram_din   = w_ldr ? bus.ldr_din : '0;
  assign bus.ddram_be    = !reset_n ? 8'h00 : (w_ldr ? bus.ldr_be : 8'hFF);
  assign bus.timeout_err = r_tout;
  assign bus.cpu_ack     = r_ack[0];
  assign bus.vid_ack     = r_ack[1];
  assign bus.snd_ack     = r_ack[2];
  assign bus.cpu_data    = r_data[0];
  assign bus.vid_data    = r_data[1];
  assign bus.snd_data    = r_data[2];
endmodule

// File: tb/tb_pgm_ddram_arb.sv
// Directed bench for pgm_ddram_arb: single read, fixed priority, audio
// starvation promotion, busy stall, timeout, loader pass-through, async reset.
module tb_pgm_ddram_arb;
  logic clk = 1'b0;
  logic reset_n = 1'b0;

  pgm_ddram_arb_if bus();

  pgm_ddram_arb #(.STARVE_LIM(8), .TIMEOUT(1023)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #10 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          auto_cli = 1'b0;
  bit          auto_mem = 1'b0;
  int          mem_cnt = 0;
  logic [63:0] mem_data;
  int          rd_cnt = 0;
  logic [28:0] glog [0:127];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance to the falling edge, then play clients/memory.
  task automatic step();
    @(negedge clk);
    if (auto_cli) begin
      bus.cpu_req = !bus.cpu_ack;
      bus.vid_req = !bus.vid_ack;
      bus.snd_req = !bus.snd_ack;
    end
    if (auto_mem) begin
      bus.ddram_dout_ready = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          bus.ddram_dout_ready = 1'b1;
          bus.ddram_dout       = mem_data;
        end
      end
      if (bus.ddram_rd) begin
        mem_cnt  = 6;
        mem_data = {35'd0, bus.ddram_addr};
      end
    end
    if (bus.ddram_rd) begin
      if (rd_cnt < 128) glog[rd_cnt] = bus.ddram_addr;
      rd_cnt++;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_rd(input string tag, output int n);
    int base;
    base = rd_cnt;
    n = 0;
    while (rd_cnt == base && n < 2000) begin step(); n++; end
    chk({tag, "_rd_seen"}, 64'(rd_cnt != base), 64'd1);
  endtask

  function automatic logic ack_of(input int w);
    case (w)
      0:       return bus.cpu_ack;
      1:       return bus.vid_ack;
      default: return bus.snd_ack;
    endcase
  endfunction

  task automatic wait_ack(input string tag, input int w, input int budget, output int n);
    n = 0;
    while (!ack_of(w) && n < budget) begin step(); n++; end
    chk({tag, "_ack_seen"}, 64'(ack_of(w)), 64'd1);
  endtask

  // Manual memory reply: ready strobe for one cycle with the given data.
  task automatic reply(input logic [63:0] d);
    bus.ddram_dout_ready = 1'b1;
    bus.ddram_dout       = d;
    step();
    bus.ddram_dout_ready = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    int found;
    bus.cpu_req = 0; bus.cpu_addr = '0;
    bus.vid_req = 0; bus.vid_addr = '0;
    bus.snd_req = 0; bus.snd_addr = '0;
    bus.ldr_active = 0; bus.ldr_addr = '0; bus.ldr_we = 0;
    bus.ldr_din = '0; bus.ldr_be = '0;
    bus.ddram_busy = 0; bus.ddram_dout_ready = 0; bus.ddram_dout = '0;

    // Reset state
    steps(2);
    chk("rst_acks", {bus.cpu_ack, bus.vid_ack, bus.snd_ack}, 0);
    chk("rst_rd_we", {bus.ddram_rd, bus.ddram_we, bus.timeout_err}, 0);
    chk("rst_be", bus.ddram_be, 0);
    chk("rst_addr", bus.ddram_addr, 0);
    chk("rst_cpu_data", bus.cpu_data, 0);
    reset_n = 1'b1;
    step();
    chk("idle_be", bus.ddram_be, 64'hFF);

    // Stray ready in IDLE does nothing
    reply(64'h1234);
    step();
    chk("stray_ready_acks", {bus.cpu_ack, bus.vid_ack, bus.snd_ack}, 0);
    chk("stray_ready_data", bus.cpu_data, 0);

    // Single cpu read
    bus.cpu_addr = 29'h100;
    bus.cpu_req  = 1'b1;
    wait_rd("cpu1", n);
    chk("cpu1_latency", n, 4);
    chk("cpu1_addr", bus.ddram_addr, 64'h100);
    step();
    chk("cpu1_rd_pulse", bus.ddram_rd, 0);
    steps(3);
    reply(64'h1122334455667788);
    chk("cpu1_ack", bus.cpu_ack, 1);
    chk("cpu1_data", bus.cpu_data, 64'h1122334455667788);
    bus.cpu_req = 1'b0;
    step();
    chk("cpu1_ack_hold1", bus.cpu_ack, 1);
    step();
    chk("cpu1_ack_hold2", bus.cpu_ack, 1);
    step();
    chk("cpu1_ack_clear", bus.cpu_ack, 0);

    // Simultaneous requests: cpu > vid > snd
    bus.cpu_addr = 29'h100; bus.vid_addr = 29'h200; bus.snd_addr = 29'h300;
    auto_mem = 1'b1;
    base = rd_cnt;
    bus.cpu_req = 1; bus.vid_req = 1; bus.snd_req = 1;
    wait_ack("sim", 2, 300, n);
    chk("sim_g0", glog[base], 64'h100);
    chk("sim_g1", glog[base+1], 64'h200);
    chk("sim_g2", glog[base+2], 64'h300);
    chk("sim_acks", {bus.cpu_ack, bus.vid_ack, bus.snd_ack}, 3'b111);
    chk("sim_vid_data", bus.vid_data, 64'h200);
    chk("sim_snd_data", bus.snd_data, 64'h300);
    bus.cpu_req = 0; bus.vid_req = 0; bus.snd_req = 0;
    steps(5);
    chk("sim_acks_clear", {bus.cpu_ack, bus.vid_ack, bus.snd_ack}, 0);

    // Starvation: cpu/vid keep re-requesting, snd must win on the 9th grant
    base = rd_cnt;
    found = 0;
    auto_cli = 1'b1;
    for (int k = 0; k < 600 && found == 0; k++) begin
      step();
      if (rd_cnt > base && glog[rd_cnt-1] == 29'h300) found = rd_cnt - base;
    end
    chk("starve_snd_grant_idx", found, 9);
    auto_cli = 1'b0;
    bus.cpu_req = 0; bus.vid_req = 0; bus.snd_req = 0;
    steps(60);
    chk("starve_drain_acks", {bus.cpu_ack, bus.vid_ack, bus.snd_ack}, 0);
    auto_mem = 1'b0;
    bus.ddram_dout_ready = 1'b0;

    // Busy stall in ISSUE
    bus.ddram_busy = 1'b1;
    bus.cpu_addr = 29'h140;
    bus.cpu_req = 1'b1;
    base = rd_cnt;
    steps(25);
    chk("busy_no_rd", rd_cnt - base, 0);
    bus.ddram_busy = 1'b0;
    wait_rd("busy", n);
    chk("busy_rd_latency", n, 1);
    step();
    chk("busy_rd_pulse", bus.ddram_rd, 0);
    steps(2);
    chk("busy_rd_count", rd_cnt - base, 1);
    reply(64'hA5A5_5A5A_0F0F_F0F0);
    chk("busy_cpu_data", bus.cpu_data, 64'hA5A5_5A5A_0F0F_F0F0);
    bus.cpu_req = 1'b0;
    steps(4);

    // Timeout on a vid read
    bus.vid_addr = 29'h2A0;
    bus.vid_req = 1'b1;
    wait_rd("tmo", n);
    wait_ack("tmo", 1, 1100, n);
    chk("tmo_cycles", n, 1023);
    chk("tmo_vid_data", bus.vid_data, '1);
    chk("tmo_err", bus.timeout_err, 1);
    bus.vid_req = 1'b0;
    steps(4);
    auto_mem = 1'b1;
    bus.snd_addr = 29'h310;
    bus.snd_req = 1'b1;
    wait_ack("post_tmo", 2, 200, n);
    chk("post_tmo_snd_data", bus.snd_data, 64'h310);
    chk("post_tmo_err_sticky", bus.timeout_err, 1);
    bus.snd_req = 1'b0;
    steps(4);
    auto_mem = 1'b0;
    bus.ddram_dout_ready = 1'b0;

    // Loader raised during a snd WAIT
    bus.snd_addr = 29'h320;
    bus.snd_req = 1'b1;
    wait_rd("ldr", n);
    bus.ldr_active = 1'b1; bus.ldr_addr = 29'h1234; bus.ldr_we = 1'b1;
    bus.ldr_din = 64'hDEAD_BEEF_0BAD_F00D; bus.ldr_be = 8'h3C;
    steps(2);
    chk("ldr_wait_we", bus.ddram_we, 0);
    chk("ldr_wait_addr", bus.ddram_addr, 64'h320);
    chk("ldr_wait_be", bus.ddram_be, 64'hFF);
    reply(64'h5555_AAAA_1234_5678);
    chk("ldr_snd_ack", bus.snd_ack, 1);
    chk("ldr_snd_data", bus.snd_data, 64'h5555_AAAA_1234_5678);
    chk("ldr_we", bus.ddram_we, 1);
    chk("ldr_addr", bus.ddram_addr, 64'h1234);
    chk("ldr_din", bus.ddram_din, 64'hDEAD_BEEF_0BAD_F00D);
    chk("ldr_be", bus.ddram_be, 64'h3C);
    bus.snd_req = 1'b0;
    bus.cpu_addr = 29'h150;
    bus.cpu_req = 1'b1;
    base = rd_cnt;
    steps(10);
    chk("ldr_blocks_cpu", rd_cnt - base, 0);
    bus.ldr_addr = 29'h777;
    #1;
    chk("ldr_addr_follow", bus.ddram_addr, 64'h777);
    bus.ldr_active = 1'b0; bus.ldr_we = 1'b0;
    #1;
    chk("ldr_off_we", bus.ddram_we, 0);
    chk("ldr_off_be", bus.ddram_be, 64'hFF);
    wait_rd("ldr_cpu", n);
    chk("ldr_cpu_latency", n, 2);
    chk("ldr_cpu_addr", bus.ddram_addr, 64'h150);
    reply(64'h0123_4567_89AB_CDEF);
    chk("ldr_cpu_data", bus.cpu_data, 64'h0123_4567_89AB_CDEF);
    bus.cpu_req = 1'b0;
    steps(4);

    // Async reset while a cpu read is in WAIT
    bus.cpu_addr = 29'h180;
    bus.cpu_req = 1'b1;
    wait_rd("arst", n);
    steps(2);
    reset_n = 1'b0;
    #1;
    chk("arst_acks", {bus.cpu_ack, bus.vid_ack, bus.snd_ack}, 0);
    chk("arst_rd", bus.ddram_rd, 0);
    chk("arst_tmo_err", bus.timeout_err, 0);
    step();
    reset_n = 1'b1;
    wait_rd("arst_regrant", n);
    chk("arst_regrant_latency", n, 4);
    chk("arst_regrant_addr", bus.ddram_addr, 64'h180);
    reply(64'h0000_0000_00C0_FFEE);
    chk("arst_cpu_ack", bus.cpu_ack, 1);
    chk("arst_cpu_data", bus.cpu_data, 64'hC0FFEE);
    bus.cpu_req = 1'b0;
    steps(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
